// File: rtl/regfile_scoreboard_if.sv
// Register file bus: two read ports, one write-back port and the issue reservation port.
// The issuing/execute side drives addresses and strobes; the register file answers.
interface regfile_scoreboard_if #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3
);
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [DATA_W-1:0]   rd_data_a;
    logic                rd_ready_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_b;
    logic                rd_ready_b;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_addr;
    logic                issue_stall;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, issue_stall, busy_mask
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, issue_stall, busy_mask
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with write-through bypass and a pending-write
// scoreboard so issue logic can stall on RAW/WAW hazards. R0 is hardwired to zero.
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic wr_valid;
    logic wr_hit_a;
    logic wr_hit_b;
    logic wr_hit_issue;
    logic issue_accept;

    // A write to R0 is treated as if it never happened, so it neither bypasses nor retires.
    assign wr_valid     = bus.wr_en && (bus.wr_addr != '0);
    assign wr_hit_a     = wr_valid && (bus.wr_addr == bus.rd_addr_a);
    assign wr_hit_b     = wr_valid && (bus.wr_addr == bus.rd_addr_b);
    assign wr_hit_issue = wr_valid && (bus.wr_addr == bus.issue_addr);

    always_comb begin
        bus.rd_data_a  = '0;
        bus.rd_ready_a = 1'b1;
        if (bus.rd_addr_a != '0) begin
            bus.rd_data_a  = wr_hit_a ? bus.wr_data : regs[bus.rd_addr_a];
            bus.rd_ready_a = !busy[bus.rd_addr_a] || wr_hit_a;
        end
    end

    always_comb begin
        bus.rd_data_b  = '0;
        bus.rd_ready_b = 1'b1;
        if (bus.rd_addr_b != '0) begin
            bus.rd_data_b  = wr_hit_b ? bus.wr_data : regs[bus.rd_addr_b];
            bus.rd_ready_b = !busy[bus.rd_addr_b] || wr_hit_b;
        end
    end

    assign bus.issue_stall = bus.issue_en && (bus.issue_addr != '0)
                             && busy[bus.issue_addr] && !wr_hit_issue;
    assign issue_accept    = bus.issue_en && (bus.issue_addr != '0) && !bus.issue_stall;

    // Retire first, then reserve, so a same-cycle write-back and re-issue leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (wr_valid) begin
            busy_next[bus.wr_addr] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[bus.issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_valid) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            busy <= busy_next;
        end
    end

    assign bus.busy_mask = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard with hand-computed expectations,
// plus a hand-written sweep that fills, reserves and re-requests every register.
module tb_regfile_scoreboard;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NVEC     = 22;

    logic clk;
    logic reset;

    int checks;
    int errors;

    regfile_scoreboard_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_scoreboard #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ie;
        logic [2:0]  ia;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] eda;
        logic        erda;
        logic [15:0] edb;
        logic        erdb;
        logic        estall;
        logic [7:0]  ebusy;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic ie, input logic [2:0] ia,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] eda, input logic erda,
                                input logic [15:0] edb, input logic erdb,
                                input logic estall, input logic [7:0] ebusy);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra = ra; v.rb = rb; v.eda = eda; v.erda = erda; v.edb = edb; v.erdb = erdb;
        v.estall = estall; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d actual %h expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic ie, input logic [2:0] ia,
                                 input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        reset          = rst;
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.issue_en   = ie;
        bus.issue_addr = ia;
        bus.rd_addr_a  = ra;
        bus.rd_addr_b  = rb;
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            rst we wa    wd        ie ia    ra    rb    eda       erda edb     erdb  stl  busy
        vecs[0]  = mk(0, 1, 3'd3, 16'h1234, 0, 3'd0, 3'd3, 3'd0, 16'h1234, 1, 16'h0000, 1, 0, 8'h00);
        vecs[1]  = mk(1, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 3'd0, 16'h1234, 1, 16'h0000, 1, 0, 8'h00);
        vecs[2]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 3'd0, 16'h0000, 1, 16'h0000, 1, 0, 8'h00);
        vecs[3]  = mk(0, 1, 3'd5, 16'hBEEF, 0, 3'd0, 3'd1, 3'd0, 16'h0000, 1, 16'h0000, 1, 0, 8'h00);
        vecs[4]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd5, 3'd0, 16'hBEEF, 1, 16'h0000, 1, 0, 8'h00);
        vecs[5]  = mk(0, 1, 3'd0, 16'hFFFF, 0, 3'd0, 3'd0, 3'd5, 16'h0000, 1, 16'hBEEF, 1, 0, 8'h00);
        vecs[6]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 3'd0, 16'h0000, 1, 16'h0000, 1, 0, 8'h00);
        vecs[7]  = mk(0, 1, 3'd2, 16'hA5A5, 0, 3'd0, 3'd2, 3'd5, 16'hA5A5, 1, 16'hBEEF, 1, 0, 8'h00);
        vecs[8]  = mk(0, 0, 3'd0, 16'h0000, 1, 3'd4, 3'd2, 3'd4, 16'hA5A5, 1, 16'h0000, 1, 0, 8'h10);
        vecs[9]  = mk(0, 0, 3'd0, 16'h0000, 1, 3'd4, 3'd4, 3'd2, 16'h0000, 0, 16'hA5A5, 1, 1, 8'h10);
        vecs[10] = mk(0, 1, 3'd4, 16'h0042, 0, 3'd0, 3'd4, 3'd4, 16'h0042, 1, 16'h0042, 1, 0, 8'h00);
        vecs[11] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd4, 3'd5, 16'h0042, 1, 16'hBEEF, 1, 0, 8'h00);
        vecs[12] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd6, 3'd6, 3'd0, 16'h0000, 1, 16'h0000, 1, 0, 8'h40);
        vecs[13] = mk(0, 1, 3'd6, 16'h7777, 1, 3'd6, 3'd6, 3'd6, 16'h7777, 1, 16'h7777, 1, 0, 8'h40);
        vecs[14] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd6, 3'd6, 16'h7777, 0, 16'h7777, 0, 0, 8'h40);
        vecs[15] = mk(0, 1, 3'd6, 16'h0001, 1, 3'd3, 3'd3, 3'd6, 16'h0000, 1, 16'h0001, 1, 0, 8'h08);
        vecs[16] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd1, 3'd3, 3'd1, 16'h0000, 0, 16'h0000, 1, 0, 8'h0A);
        vecs[17] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd0, 3'd0, 3'd1, 16'h0000, 1, 16'h0000, 0, 0, 8'h0A);
        vecs[18] = mk(1, 1, 3'd1, 16'h1111, 1, 3'd7, 3'd1, 3'd7, 16'h1111, 1, 16'h0000, 1, 0, 8'h00);
        vecs[19] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd1, 3'd3, 16'h0000, 1, 16'h0000, 1, 0, 8'h00);
        vecs[20] = mk(0, 1, 3'd1, 16'h2222, 0, 3'd0, 3'd7, 3'd1, 16'h0000, 1, 16'h2222, 1, 0, 8'h00);
        vecs[21] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd1, 3'd6, 16'h2222, 1, 16'h0000, 1, 0, 8'h00);

        reset          = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.rd_addr_a  = 3'd3;
        bus.rd_addr_b  = 3'd7;
        @(posedge clk);
        @(posedge clk);

        // Reset state, observed with no write or issue in flight.
        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 3'd7);
        checkOutput("reset_busy", -1, {8'h00, bus.busy_mask}, 16'h0000);
        checkOutput("reset_rd_data_a", -1, bus.rd_data_a, 16'h0000);
        checkOutput("reset_rd_ready_a", -1, {15'd0, bus.rd_ready_a}, 16'h0001);
        checkOutput("reset_issue_stall", -1, {15'd0, bus.issue_stall}, 16'h0000);
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                          vecs[i].ie, vecs[i].ia, vecs[i].ra, vecs[i].rb);
            checkOutput("rd_data_a", i, bus.rd_data_a, vecs[i].eda);
            checkOutput("rd_ready_a", i, {15'd0, bus.rd_ready_a}, {15'd0, vecs[i].erda});
            checkOutput("rd_data_b", i, bus.rd_data_b, vecs[i].edb);
            checkOutput("rd_ready_b", i, {15'd0, bus.rd_ready_b}, {15'd0, vecs[i].erdb});
            checkOutput("issue_stall", i, {15'd0, bus.issue_stall}, {15'd0, vecs[i].estall});
            @(posedge clk);
            #1;
            checkOutput("busy_mask", i, {8'h00, bus.busy_mask}, {8'h00, vecs[i].ebusy});
        end

        // Fill every register, reserve all of them, then re-request each one.
        for (int r = 0; r < NUM_REGS; r++) begin
            applyStimulus(0, 1, 3'(r), 16'h1000 + 16'(r), 0, 3'd0, 3'd0, 3'd0);
            @(posedge clk);
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            applyStimulus(0, 0, 3'd0, 16'h0000, 1, 3'(r), 3'(r), 3'(NUM_REGS - 1 - r));
            checkOutput("sweep_rd_a", 100 + r, bus.rd_data_a, (r == 0) ? 16'h0000 : 16'h1000 + 16'(r));
            checkOutput("sweep_rd_b", 100 + r, bus.rd_data_b,
                        (r == NUM_REGS - 1) ? 16'h0000 : 16'h1000 + 16'(NUM_REGS - 1 - r));
            checkOutput("sweep_stall", 100 + r, {15'd0, bus.issue_stall}, 16'h0000);
            @(posedge clk);
        end
        #1;
        checkOutput("sweep_busy", 200, {8'h00, bus.busy_mask}, 16'h00FE);
        for (int r = 0; r < NUM_REGS; r++) begin
            applyStimulus(0, 0, 3'd0, 16'h0000, 1, 3'(r), 3'(r), 3'd0);
            checkOutput("sweep_restall", 300 + r, {15'd0, bus.issue_stall},
                        (r == 0) ? 16'h0000 : 16'h0001);
            checkOutput("sweep_ready_a", 300 + r, {15'd0, bus.rd_ready_a},
                        (r == 0) ? 16'h0001 : 16'h0000);
            @(posedge clk);
        end
        #1;
        checkOutput("sweep_busy_held", 400, {8'h00, bus.busy_mask}, 16'h00FE);

        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 3'd0);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
